// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, state type and counter sizing for the multiply/divide unit
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        SIGN = 2'b10
    } state_t;

    // Iteration counter must be able to hold the value W itself.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - conditional two's-complement negation
//
// Ports:
//   value   in  DATA_WIDTH  operand
//   negate  in  1           when set, result = -value, otherwise result = value
//   result  out DATA_WIDTH  conditionally negated operand
module mdu_sign_fix #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  negate,
    output logic [DATA_WIDTH-1:0] result
);

    assign result = negate ? (~value + DATA_WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start_i, op_i          issue pulse and operation (MULT/MULTU/DIV/DIVU)
//   a_i, b_i               rs/rt operands
//   cancel_i               aborts an in-flight op, blocks a same-cycle start
//   mthi_i, mtlo_i, wdata_i  direct HI/LO writes, honoured only when idle
//   busy_o                 op in flight
//   done_o, div_zero_o     result-written pulse, divide-by-zero pulse
//   hi_o, lo_o             HI/LO registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  cancel_i,
    input  logic                  mthi_i,
    input  logic                  mtlo_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  div_zero_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = cnt_width(W);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic            neg_q;
    logic            neg_r;
    logic [W-1:0]    mag_b;
    logic [W-1:0]    a_raw;
    logic [2*W-1:0]  acc;

    // MULT and DIV have op_i[0] clear.
    logic signed_op;
    assign signed_op = ~op_i[0];

    logic [W-1:0] abs_a, abs_b;
    mdu_sign_fix #(.DATA_WIDTH(W)) u_abs_a (.value(a_i), .negate(signed_op & a_i[W-1]), .result(abs_a));
    mdu_sign_fix #(.DATA_WIDTH(W)) u_abs_b (.value(b_i), .negate(signed_op & b_i[W-1]), .result(abs_b));

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_b} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc[W-1:1]};

    // Divide step: acc = {partial remainder, dividend bits / quotient bits}.
    // Remainder stays below the divisor, so bit W of the difference is the borrow.
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_next;
    assign div_shift = acc[2*W-1:W-1];
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_next  = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                                   : {div_diff[W-1:0],  acc[W-2:0], 1'b1};

    logic [2*W-1:0] prod_fixed;
    logic [W-1:0]   quo_fixed, rem_fixed;
    mdu_sign_fix #(.DATA_WIDTH(2*W)) u_fix_prod (.value(acc), .negate(neg_q), .result(prod_fixed));
    mdu_sign_fix #(.DATA_WIDTH(W))   u_fix_quo  (.value(acc[W-1:0]), .negate(neg_q), .result(quo_fixed));
    mdu_sign_fix #(.DATA_WIDTH(W))   u_fix_rem  (.value(acc[2*W-1:W]), .negate(neg_r), .result(rem_fixed));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            is_div     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            mag_b      <= '0;
            a_raw      <= '0;
            acc        <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            div_zero_o <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
        end else begin
            done_o     <= 1'b0;
            div_zero_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi_i) hi_o <= wdata_i;
                    if (mtlo_i) lo_o <= wdata_i;
                    if (start_i && !cancel_i) begin
                        state  <= RUN;
                        busy_o <= 1'b1;
                        cnt    <= CW'(W);
                        is_div <= op_i[1];
                        mag_b  <= abs_b;
                        a_raw  <= a_i;
                        acc    <= {{W{1'b0}}, abs_a};
                        neg_q  <= signed_op & (a_i[W-1] ^ b_i[W-1]);
                        neg_r  <= signed_op & a_i[W-1];
                    end
                end
                RUN: begin
                    if (cancel_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= SIGN;
                    end
                end
                SIGN: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    if (!cancel_i) begin
                        done_o <= 1'b1;
                        if (!is_div) begin
                            {hi_o, lo_o} <= prod_fixed;
                        end else if (mag_b == '0) begin
                            hi_o       <= a_raw;
                            lo_o       <= '1;
                            div_zero_o <= 1'b1;
                        end else begin
                            hi_o <= rem_fixed;
                            lo_o <= quo_fixed;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with an arithmetic reference model
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_i;
    logic [1:0]   op_i;
    logic [W-1:0] a_i, b_i;
    logic         cancel_i;
    logic         mthi_i, mtlo_i;
    logic [W-1:0] wdata_i;
    logic         busy_o, done_o, div_zero_o;
    logic [W-1:0] hi_o, lo_o;

    mult_div_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .cancel_i(cancel_i), .mthi_i(mthi_i),
        .mtlo_i(mtlo_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
        .div_zero_o(div_zero_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero
    // and the remainder takes the dividend's sign, matching MIPS DIV.
    function automatic exp_t ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] r64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        e.dz = 1'b0;
        e.cyc = 0;
        e.hi = '0;
        e.lo = '0;
        if (op[1] && b == '0) begin
            e.hi = a;
            e.lo = '1;
            e.dz = 1'b1;
        end else begin
            case (op)
                2'b00: begin r64 = sa * sb; e.hi = r64[2*W-1:W]; e.lo = r64[W-1:0]; end
                2'b01: begin r64 = ua * ub; e.hi = r64[2*W-1:W]; e.lo = r64[W-1:0]; end
                2'b10: begin r64 = sa / sb; e.lo = r64[W-1:0]; r64 = sa % sb; e.hi = r64[W-1:0]; end
                default: begin r64 = ua / ub; e.lo = r64[W-1:0]; r64 = ua % ub; e.hi = r64[W-1:0]; end
            endcase
        end
        return e;
    endfunction

    // Monitor: pops one expectation per done_o pulse.
    exp_t got;
    always @(negedge clk) begin
        if (!reset) begin
            if (done_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
                end else begin
                    got = sb_q.pop_front();
                    check("result_hi", hi_o, got.hi);
                    check("result_lo", lo_o, got.lo);
                    check("div_zero", div_zero_o, got.dz);
                    check("done_cycle", cyc, got.cyc);
                end
            end else if (div_zero_o) begin
                checks++;
                failures++;
                $display("FAIL div_zero_without_done actual=1 required=0 (t=%0t)", $time);
            end
        end
    end

    // Called at a negedge; returns at the negedge where the result is visible.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int t0;
        int bad;
        e = ref_model(op, a, b);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        t0 = cyc;
        start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
        e.cyc = t0 + W + 1;
        sb_q.push_back(e);
        model_hi = e.hi;
        model_lo = e.lo;
        bad = 0;
        repeat (W + 1) begin
            @(negedge clk);
            if (!busy_o) bad++;
        end
        check("busy_during_op", bad, 0);
        @(negedge clk);
        check("busy_after_op", busy_o, 0);
    endtask

    task automatic mt(input logic hi_en, input logic lo_en, input logic [W-1:0] data);
        mthi_i = hi_en; mtlo_i = lo_en; wdata_i = data;
        @(posedge clk); #1;
        mthi_i = 1'b0; mtlo_i = 1'b0;
        if (hi_en) model_hi = data;
        if (lo_en) model_lo = data;
        @(negedge clk);
        check("mt_hi", hi_o, model_hi);
        check("mt_lo", lo_o, model_lo);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return W'($urandom());
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
        cancel_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0; wdata_i = '0;
        #1;
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_div_zero", div_zero_o, 0);
        check("reset_hi", hi_o, 0);
        check("reset_lo", lo_o, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors, issued back to back.
        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        issue(2'b11, 32'h0000_0007, 32'h0000_0002);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b11, 32'h0000_1234, 32'h0000_0000);
        issue(2'b10, 32'hFFFF_FF00, 32'h0000_0000);

        // Direct writes: both at once, then each alone.
        mt(1'b1, 1'b1, 32'hDEAD_BEEF);
        mt(1'b1, 1'b0, 32'h0BAD_F00D);
        mt(1'b0, 1'b1, 32'h1357_9BDF);

        // MTLO together with an accepted start: the op result wins.
        mtlo_i = 1'b1; wdata_i = 32'h5555_AAAA;
        issue(2'b01, 32'h0000_0003, 32'h0000_0005);

        // Cancel in cycle 10; mid-op start and MTHI must be ignored.
        mt(1'b0, 1'b1, 32'hA5A5_A5A5);
        start_i = 1'b1; op_i = 2'b00; a_i = 32'h0000_0011; b_i = 32'h0000_0022;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 5) begin
                start_i = 1'b1; op_i = 2'b11; mthi_i = 1'b1; wdata_i = 32'h1234_5678;
            end else if (c == 6) begin
                start_i = 1'b0; mthi_i = 1'b0;
            end
        end
        cancel_i = 1'b1;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        @(negedge clk);
        check("cancel_busy", busy_o, 0);
        check("cancel_lo", lo_o, model_lo);
        check("cancel_hi", hi_o, model_hi);
        repeat (W + 4) @(negedge clk);

        // cancel_i in IDLE blocks a same-cycle start.
        start_i = 1'b1; cancel_i = 1'b1; op_i = 2'b01;
        @(posedge clk); #1;
        start_i = 1'b0; cancel_i = 1'b0;
        @(negedge clk);
        check("idle_cancel_busy", busy_o, 0);

        // Asynchronous reset in cycle 15 of a DIVU.
        mt(1'b1, 1'b1, 32'hFFFF_0000);
        start_i = 1'b1; op_i = 2'b11; a_i = 32'h0000_9999; b_i = 32'h0000_0013;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (14) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_busy", busy_o, 0);
        check("async_reset_hi", hi_o, 0);
        check("async_reset_lo", lo_o, 0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(2'b00, 32'h0001_0003, 32'hFFFF_FFF0);

        // Randomised ops, operands biased toward corner values.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = W'($urandom());
            end
            issue(op, pick(), pick());
        end

        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
